ddram_arb: RTL and testbench
============================

# ddram_arb

Three-client arbiter for the shared DDR3 Avalon port on DDRAM_CLK. It takes toggle-handshake read/write requests from up to three core-side clients, such as cartridge save RAM, the CD/PCM buffer and the debug/rewind path. It grants one client at a time in round-robin order and issues single-beat commands into the 0x30000000 window. It replaces per-client DDRAM instances, so every memory user in the core sits behind one sequencer.

## Interface
Parameters:
- BASE, 4'b0011, upper 4 bits of DDRAM_ADDR (selects the 0x30000000 region).
- N, 3, client count; fixed at 3 and held in the package.

Ports:
- DDRAM_CLK  in  1  clock.
- reset  in  1  synchronous, active-high.
- DDRAM_BUSY  in  1  Avalon waitrequest.
- DDRAM_BURSTCNT  out  8  constant 1.
- DDRAM_ADDR  out  29  {BASE, addr[27:3]}.
- DDRAM_DOUT  in  64  read data.
- DDRAM_DOUT_READY  in  1  read data valid.
- DDRAM_RD  out  1  read command.
- DDRAM_WE  out  1  write command.
- DDRAM_DIN  out  64  {4{wdata}}.
- DDRAM_BE  out  8  write: 8'd3 << {addr[2:1],1'b0}; read: 8'hFF.
- cN_addr  in  28  byte address, per client N = 0..2.
- cN_din  in  16  write data.
- cN_wr  in  1  1 = write, 0 = read; sampled with the request.
- cN_req  in  1  toggle request.
- cN_ack  out  1  toggle acknowledge.
- cN_dout  out  64  last read qword for client N, held until its next read completes.

## Operation
- A client is pending when cN_req != cN_ack. Clients must hold addr, din and wr stable while pending.
- State machine:
  - IDLE: runs only when !DDRAM_BUSY. The picker selects a pending client, starting at the client after `last`. On a pick: latch addr/din/wr, `cur`, `last` <= pick. Assert RD or WE. Go to WR or RD.
  - WR: when !DDRAM_BUSY (command accepted), drop WE, toggle c[cur]_ack, return to IDLE.
  - RD: when !DDRAM_BUSY, drop RD. Stay in RD until DDRAM_DOUT_READY, then c[cur]_dout <= DDRAM_DOUT, toggle c[cur]_ack, return to IDLE.
- While DDRAM_BUSY, all command outputs and ADDR/DIN/BE hold their values.
- At most one outstanding command.
- A request arriving for the client currently in service is a new request; it is served on a later grant.
- A DOUT_READY in IDLE or WR is ignored and has no side effect.
- Reset mid-operation: return to IDLE, deassert RD/WE, clear all acks. A read in flight is abandoned. Any DOUT_READY after reset is ignored.

## Timing
- Reset values: RD=0, WE=0, all cN_ack=0, all cN_dout=0, state=IDLE, last=2 (so client 0 is first), ADDR/DIN/BE=0.
- Write latency with BUSY low: req toggle at cycle t. WE is high in cycle t+1. Ack toggles visible in cycle t+2.
- Read latency: ack toggles 1 cycle after the DOUT_READY cycle. dout is valid in the same cycle the ack toggles.
- Every BUSY-high cycle adds one cycle of latency, one for one.
- Back-to-back: a new grant can issue in the cycle right after a return to IDLE. Minimum 2 cycles per write, 3 per read.
- Fairness: with all three clients pending continuously, grants rotate 0,1,2,0,… Worst-case wait is 2 services.

## Structure
- Package ddram_arb_pkg holds:
  - state enum {IDLE, WR, RD};
  - N_CLIENTS=3;
  - client-index typedef (2 bits);
  - DDR_BASE=4'b0011.
- One sub-module, ddram_rr_pick: combinational round-robin picker. Inputs are pending[2:0] and last. Outputs are valid and index.

## Test plan
- Single write: c0 addr=28'h0000006, din=16'hBEEF, toggle req → one WE pulse with ADDR={4'b0011,25'h0}, DIN=64'hBEEF_BEEF_BEEF_BEEF, BE=8'hC0; c0_ack toggles at t+2.
- Single read: c1 addr=28'h0000010, DOUT_READY 4 cycles after RD with DOUT=64'h0123_4567_89AB_CDEF → one RD pulse with BE=8'hFF; c1_dout equals that value; c1_ack toggles; c0 and c2 untouched.
- Contention: all three requests toggled in the same cycle → grants in order 0,1,2. Re-toggle all three → order 0,1,2 again, with no starvation.
- BUSY stall: hold BUSY high for 5 cycles while WE is asserted → WE, ADDR and DIN stable throughout; exactly one write accepted; ack delayed by 5 cycles.
- Reset mid-read: assert reset after RD is accepted and before DOUT_READY, then deliver DOUT_READY after release → acks=0, state IDLE, no dout update.
- Spurious DOUT_READY in IDLE → no ack or dout change.

Source files
------------

// File: rtl/ddram_arb_pkg.sv
// Shared types and constants for the DDR3 client arbiter.
// Holds the sequencer state encoding and client indexing.
package ddram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD
  } state_e;

  localparam int N_CLIENTS = 3;

  typedef logic [1:0] cidx_t;

  localparam logic [3:0] DDR_BASE = 4'b0011;

  // 16-bit lane enable inside the 64-bit qword
  function automatic logic [7:0] lane_be(input logic [1:0] w);
    return 8'd3 << {w, 1'b0};
  endfunction

endpackage

// File: rtl/ddram_rr_pick.sv
// Combinational round-robin picker over three pending clients.
// Search starts at the client after the last one granted.
module ddram_rr_pick
  import ddram_arb_pkg::*;
(
  input  logic [N_CLIENTS-1:0] pending_i,
  input  cidx_t                last_i,
  output logic                 valid_o,
  output cidx_t                idx_o
);

  always_comb begin
    valid_o = |pending_i;
    idx_o   = 2'd0;
    case (last_i)
      2'd0: idx_o = pending_i[1] ? 2'd1 :
                    pending_i[2] ? 2'd2 : 2'd0;
      2'd1: idx_o = pending_i[2] ? 2'd2 :
                    pending_i[0] ? 2'd0 : 2'd1;
      default: idx_o = pending_i[0] ? 2'd0 :
                       pending_i[1] ? 2'd1 : 2'd2;
    endcase
  end

endmodule

// File: rtl/ddram_arb.sv
// Three-client toggle-handshake arbiter onto the shared DDR3 Avalon port.
// Single-beat commands, one outstanding, round-robin grants.
module ddram_arb
  import ddram_arb_pkg::*;
#(
  parameter logic [3:0] BASE = DDR_BASE,
  parameter int         N    = N_CLIENTS
) (
  input  logic        DDRAM_CLK,
  input  logic        reset,
  input  logic        DDRAM_BUSY,
  output logic [7:0]  DDRAM_BURSTCNT,
  output logic [28:0] DDRAM_ADDR,
  input  logic [63:0] DDRAM_DOUT,
  input  logic        DDRAM_DOUT_READY,
  output logic        DDRAM_RD,
  output logic        DDRAM_WE,
  output logic [63:0] DDRAM_DIN,
  output logic [7:0]  DDRAM_BE,
  input  logic [27:0] c0_addr_i,
  input  logic [15:0] c0_din_i,
  input  logic        c0_wr_i,
  input  logic        c0_req_i,
  output logic        c0_ack_o,
  output logic [63:0] c0_dout_o,
  input  logic [27:0] c1_addr_i,
  input  logic [15:0] c1_din_i,
  input  logic        c1_wr_i,
  input  logic        c1_req_i,
  output logic        c1_ack_o,
  output logic [63:0] c1_dout_o,
  input  logic [27:0] c2_addr_i,
  input  logic [15:0] c2_din_i,
  input  logic        c2_wr_i,
  input  logic        c2_req_i,
  output logic        c2_ack_o,
  output logic [63:0] c2_dout_o
);

  logic [27:0] addr_a [N];
  logic [15:0] din_a  [N];
  logic [N-1:0] wr_v;
  logic [N-1:0] req_v;
  logic [N-1:0] pending;

  state_e      state_q, state_d;
  cidx_t       cur_q, cur_d;
  cidx_t       last_q, last_d;
  logic        rd_q, rd_d;
  logic        we_q, we_d;
  logic [28:0] addr_q, addr_d;
  logic [63:0] din_q, din_d;
  logic [7:0]  be_q, be_d;
  logic [N-1:0] ack_q, ack_d;
  logic [63:0] dout_q [N];
  logic [63:0] dout_d [N];

  logic  pick_v;
  cidx_t pick_i;
  logic  unused_addr_lsb;

  assign addr_a[0] = c0_addr_i;
  assign addr_a[1] = c1_addr_i;
  assign addr_a[2] = c2_addr_i;
  assign din_a[0]  = c0_din_i;
  assign din_a[1]  = c1_din_i;
  assign din_a[2]  = c2_din_i;
  assign wr_v      = {c2_wr_i, c1_wr_i, c0_wr_i};
  assign req_v     = {c2_req_i, c1_req_i, c0_req_i};
  assign pending   = req_v ^ ack_q;

  // byte lane inside a 16-bit word is never addressed
  assign unused_addr_lsb = ^{c0_addr_i[0], c1_addr_i[0], c2_addr_i[0]};

  ddram_rr_pick u_pick (
    .pending_i (pending),
    .last_i    (last_q),
    .valid_o   (pick_v),
    .idx_o     (pick_i)
  );

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    last_d  = last_q;
    rd_d    = rd_q;
    we_d    = we_q;
    addr_d  = addr_q;
    din_d   = din_q;
    be_d    = be_q;
    ack_d   = ack_q;
    dout_d  = dout_q;
    unique case (state_q)
      IDLE: begin
        if (!DDRAM_BUSY && pick_v) begin
          cur_d  = pick_i;
          last_d = pick_i;
          addr_d = {BASE, addr_a[pick_i][27:3]};
          din_d  = {4{din_a[pick_i]}};
          if (wr_v[pick_i]) begin
            we_d    = 1'b1;
            be_d    = lane_be(addr_a[pick_i][2:1]);
            state_d = WR;
          end else begin
            rd_d    = 1'b1;
            be_d    = 8'hFF;
            state_d = RD;
          end
        end
      end
      WR: begin
        if (!DDRAM_BUSY) begin
          we_d         = 1'b0;
          ack_d[cur_q] = ~ack_q[cur_q];
          state_d      = IDLE;
        end
      end
      RD: begin
        // data only counts once the command itself was taken
        if (rd_q) begin
          if (!DDRAM_BUSY) rd_d = 1'b0;
        end else if (DDRAM_DOUT_READY) begin
          dout_d[cur_q] = DDRAM_DOUT;
          ack_d[cur_q]  = ~ack_q[cur_q];
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge DDRAM_CLK) begin
    if (reset) begin
      state_q <= IDLE;
      cur_q   <= 2'd0;
      last_q  <= 2'd2;
      rd_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      be_q    <= '0;
      ack_q   <= '0;
      for (int i = 0; i < N; i++) dout_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      be_q    <= be_d;
      ack_q   <= ack_d;
      for (int i = 0; i < N; i++) dout_q[i] <= dout_d[i];
    end
  end

  assign DDRAM_BURSTCNT = 8'd1;
  assign DDRAM_ADDR     = addr_q;
  assign DDRAM_DIN      = din_q;
  assign DDRAM_BE       = be_q;
  assign DDRAM_RD       = rd_q;
  assign DDRAM_WE       = we_q;
  assign c0_ack_o       = ack_q[0];
  assign c1_ack_o       = ack_q[1];
  assign c2_ack_o       = ack_q[2];
  assign c0_dout_o      = dout_q[0];
  assign c1_dout_o      = dout_q[1];
  assign c2_dout_o      = dout_q[2];

endmodule

// File: tb/tb_ddram_arb.sv
// Scoreboard bench for ddram_arb: a memory-level model predicts
// grant order, bus commands and read data; a monitor checks them.
module tb_ddram_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        busy;
  logic [7:0]  bcnt;
  logic [28:0] daddr;
  logic [63:0] ddout;
  logic        drdy;
  logic        rd, we;
  logic [63:0] ddin;
  logic [7:0]  dbe;

  logic [27:0] c_addr [3];
  logic [15:0] c_din  [3];
  logic        c_wr   [3];
  logic [2:0]  c_req;
  wire  [2:0]  c_ack;
  wire  [63:0] c_dout [3];

  logic        resp_rdy, tb_rdy;
  logic [63:0] resp_dat, tb_dat;
  int          resp_lat;
  int          busy_force;
  logic        busy_rand;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign drdy  = resp_rdy | tb_rdy;
  assign ddout = tb_rdy ? tb_dat : resp_dat;

  ddram_arb dut (
    .DDRAM_CLK        (clk),
    .reset            (reset),
    .DDRAM_BUSY       (busy),
    .DDRAM_BURSTCNT   (bcnt),
    .DDRAM_ADDR       (daddr),
    .DDRAM_DOUT       (ddout),
    .DDRAM_DOUT_READY (drdy),
    .DDRAM_RD         (rd),
    .DDRAM_WE         (we),
    .DDRAM_DIN        (ddin),
    .DDRAM_BE         (dbe),
    .c0_addr_i        (c_addr[0]),
    .c0_din_i         (c_din[0]),
    .c0_wr_i          (c_wr[0]),
    .c0_req_i         (c_req[0]),
    .c0_ack_o         (c_ack[0]),
    .c0_dout_o        (c_dout[0]),
    .c1_addr_i        (c_addr[1]),
    .c1_din_i         (c_din[1]),
    .c1_wr_i          (c_wr[1]),
    .c1_req_i         (c_req[1]),
    .c1_ack_o         (c_ack[1]),
    .c1_dout_o        (c_dout[1]),
    .c2_addr_i        (c_addr[2]),
    .c2_din_i         (c_din[2]),
    .c2_wr_i          (c_wr[2]),
    .c2_req_i         (c_req[2]),
    .c2_ack_o         (c_ack[2]),
    .c2_dout_o        (c_dout[2])
  );

  typedef struct {
    logic        rd;
    logic [28:0] addr;
    logic [63:0] din;
    logic [7:0]  be;
  } cmd_t;

  typedef struct {
    int          client;
    logic        rd;
    logic [63:0] data;
  } done_t;

  cmd_t  exp_cmd  [$];
  done_t exp_done [$];

  logic [63:0] mmem [int];
  logic [63:0] dmem [int];
  int model_last = 2;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] init_val(int q);
    return 64'hC0DE_0000_0000_0000 | (64'(q) * 64'h0000_0001_0003_0007);
  endfunction

  function automatic logic [63:0] merge(logic [63:0] old,
                                        logic [63:0] d,
                                        logic [7:0] be);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++)
      if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [63:0] mget(int q);
    return mmem.exists(q) ? mmem[q] : init_val(q);
  endfunction

  function automatic logic [63:0] dget(int q);
    return dmem.exists(q) ? dmem[q] : init_val(q);
  endfunction

  task automatic preload(int q, logic [63:0] v);
    mmem[q] = v;
    dmem[q] = v;
  endtask

  // predict service order from the grant rotation, then fire the toggles
  task automatic issue(logic [2:0] mask);
    int c, q, lastc;
    cmd_t e;
    done_t d;
    lastc = model_last;
    for (int k = 1; k <= 3; k++) begin
      c = (model_last + k) % 3;
      if (mask[c]) begin
        q      = int'(c_addr[c][27:3]);
        e.rd   = !c_wr[c];
        e.addr = {4'b0011, c_addr[c][27:3]};
        e.din  = {4{c_din[c]}};
        e.be   = e.rd ? 8'hFF : (8'd3 << (2 * int'(c_addr[c][2:1])));
        exp_cmd.push_back(e);
        d.client = c;
        d.rd     = e.rd;
        d.data   = e.rd ? mget(q) : 64'd0;
        if (!e.rd) mmem[q] = merge(mget(q), e.din, e.be);
        exp_done.push_back(d);
        lastc = c;
      end
    end
    model_last = lastc;
    c_req = c_req ^ mask;
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic latency(int c, int exp, string nm);
    int k;
    k = 0;
    while (k < 80) begin
      @(negedge clk);
      if (c_ack[c] == c_req[c]) break;
      k++;
    end
    chk(nm, 64'(k), 64'(exp));
  endtask

  task automatic wait_done(int lim);
    int k;
    k = 0;
    while (c_ack != c_req && k < lim) begin
      @(negedge clk);
      k++;
    end
    if (c_ack != c_req) begin
      tests++;
      fails++;
      $display("FAIL round_timeout: ack %b req %b", c_ack, c_req);
    end
    step(1);
  endtask

  initial begin
    busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (busy_force > 0) begin
        busy = 1'b1;
        busy_force--;
      end else begin
        busy = busy_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
      end
    end
  end

  // DDR side: accepts commands, applies byte enables, returns reads late
  initial begin
    logic acc_rd, acc_wr;
    logic [63:0] wdat, rdat;
    logic [7:0] wbe;
    int q, cnt;
    resp_rdy = 1'b0;
    resp_dat = '0;
    cnt = 0;
    rdat = '0;
    forever begin
      @(negedge clk);
      acc_rd = rd && !busy && !reset;
      acc_wr = we && !busy && !reset;
      q      = int'(daddr[24:0]);
      wdat   = ddin;
      wbe    = dbe;
      @(posedge clk);
      #1;
      resp_rdy = 1'b0;
      if (acc_wr) dmem[q] = merge(dget(q), wdat, wbe);
      if (acc_rd) begin
        cnt  = (resp_lat > 0) ? resp_lat : int'($urandom_range(1, 4));
        rdat = dget(q);
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          resp_rdy = 1'b1;
          resp_dat = rdat;
        end
      end
    end
  end

  initial begin
    logic [2:0]  prev_ack;
    logic [63:0] prev_dout [3];
    cmd_t  e;
    done_t d;
    prev_ack = '0;
    for (int i = 0; i < 3; i++) prev_dout[i] = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if ((rd || we) && !busy) begin
          if (exp_cmd.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_cmd: rd %b we %b addr %h", rd, we, daddr);
          end else begin
            e = exp_cmd.pop_front();
            chk("cmd_kind", {62'd0, rd, we}, {62'd0, e.rd, !e.rd});
            chk("cmd_addr", 64'(daddr), 64'(e.addr));
            chk("cmd_be", 64'(dbe), 64'(e.be));
            if (!e.rd) chk("cmd_din", ddin, e.din);
          end
        end
        for (int i = 0; i < 3; i++) begin
          if (c_ack[i] != prev_ack[i]) begin
            if (exp_done.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL unexpected_ack: client %0d", i);
            end else begin
              d = exp_done.pop_front();
              chk("ack_client", 64'(i), 64'(d.client));
              if (d.rd) chk("rd_dout", c_dout[i], d.data);
              else chk("wr_dout_hold", c_dout[i], prev_dout[i]);
            end
          end else if (c_dout[i] !== prev_dout[i]) begin
            chk("dout_hold", c_dout[i], prev_dout[i]);
          end
        end
      end
      prev_ack = c_ack;
      for (int i = 0; i < 3; i++) prev_dout[i] = c_dout[i];
    end
  end

  initial begin
    logic [63:0] saved [3];
    logic [2:0]  mask;
    reset      = 1'b1;
    busy_rand  = 1'b0;
    busy_force = 0;
    resp_lat   = 0;
    tb_rdy     = 1'b0;
    tb_dat     = '0;
    c_req      = '0;
    for (int i = 0; i < 3; i++) begin
      c_addr[i] = '0;
      c_din[i]  = '0;
      c_wr[i]   = 1'b0;
    end
    step(3);
    @(negedge clk);
    chk("rst_rd", 64'(rd), 64'd0);
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_ack", 64'(c_ack), 64'd0);
    chk("rst_addr", 64'(daddr), 64'd0);
    chk("rst_din", ddin, 64'd0);
    chk("rst_be", 64'(dbe), 64'd0);
    chk("burstcnt", 64'(bcnt), 64'd1);
    for (int i = 0; i < 3; i++) chk("rst_dout", c_dout[i], 64'd0);
    step(1);
    reset = 1'b0;
    model_last = 2;
    step(1);

    c_addr[0] = 28'h0000006;
    c_din[0]  = 16'hBEEF;
    c_wr[0]   = 1'b1;
    issue(3'b001);
    latency(0, 2, "wr_latency");
    step(1);

    preload(2, 64'h0123_4567_89AB_CDEF);
    c_addr[1] = 28'h0000010;
    c_wr[1]   = 1'b0;
    resp_lat  = 4;
    issue(3'b010);
    latency(1, 6, "rd_latency");
    chk("rd_c1_dout", c_dout[1], 64'h0123_4567_89AB_CDEF);
    chk("rd_c0_ack", 64'(c_ack[0]), 64'(c_req[0]));
    chk("rd_c2_ack", 64'(c_ack[2]), 64'(c_req[2]));
    resp_lat = 0;
    step(1);

    c_addr[2] = 28'h0000102;
    c_din[2]  = 16'h2222;
    c_wr[2]   = 1'b1;
    issue(3'b100);
    wait_done(40);

    for (int i = 0; i < 3; i++) begin
      c_addr[i] = 28'(32 * i + 2 * i);
      c_din[i]  = 16'(16'hA000 + i);
      c_wr[i]   = 1'b1;
    end
    issue(3'b111);
    latency(2, 6, "b2b_writes");
    step(1);
    resp_lat = 1;
    for (int i = 0; i < 3; i++) c_wr[i] = 1'b0;
    issue(3'b111);
    latency(2, 9, "b2b_reads");
    resp_lat = 0;
    step(1);

    c_addr[0] = 28'h0000020;
    c_din[0]  = 16'h1234;
    c_wr[0]   = 1'b1;
    issue(3'b001);
    busy_force = 5;
    @(negedge clk);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("stall_we", 64'(we), 64'd1);
      chk("stall_addr", 64'(daddr), {35'd0, 4'b0011, 25'd4});
      chk("stall_din", ddin, {4{16'h1234}});
      if (k == 6) chk("stall_ack_wait", 64'(c_ack[0]), 64'(!c_req[0]));
    end
    @(negedge clk);
    chk("stall_ack", 64'(c_ack[0]), 64'(c_req[0]));
    step(1);

    c_addr[1] = 28'h0000008;
    c_wr[1]   = 1'b0;
    resp_lat  = 6;
    issue(3'b010);
    step(2);
    reset = 1'b1;
    exp_cmd.delete();
    exp_done.delete();
    c_req = '0;
    step(2);
    reset = 1'b0;
    model_last = 2;
    step(6);
    chk("rstrd_ack", 64'(c_ack), 64'd0);
    chk("rstrd_rd", 64'(rd), 64'd0);
    chk("rstrd_we", 64'(we), 64'd0);
    chk("rstrd_dout", c_dout[1], 64'd0);
    resp_lat = 0;

    busy_rand = 1'b1;
    for (int r = 0; r < 150; r++) begin
      mask = 3'($urandom_range(1, 7));
      for (int i = 0; i < 3; i++) begin
        if (mask[i]) begin
          c_addr[i] = 28'($urandom_range(0, 63));
          c_din[i]  = 16'($urandom);
          c_wr[i]   = 1'($urandom_range(0, 1));
        end
      end
      issue(mask);
      wait_done(200);
    end
    busy_rand = 1'b0;
    step(3);

    for (int i = 0; i < 3; i++) saved[i] = c_dout[i];
    tb_dat = 64'hDEAD_0000_BAD0_F00D;
    tb_rdy = 1'b1;
    step(1);
    tb_rdy = 1'b0;
    step(3);
    chk("spur_ack", 64'(c_ack), 64'(c_req));
    for (int i = 0; i < 3; i++) chk("spur_dout", c_dout[i], saved[i]);

    chk("sb_cmd_empty", 64'(exp_cmd.size()), 64'd0);
    chk("sb_done_empty", 64'(exp_done.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
